scan_tx: RTL and testbench
==========================

SCAN_TX -- requirements
Module: scan_tx

Interface
REQ-001 Parameter DIV, default 250: Clk cycles per serial_clk half-period; legal range 2..4095.
REQ-002 Parameter GAP_LEN, default 4: idle serial_clk periods between frames; legal range 1..15.
REQ-003 Parameter DEPTH, fixed 4: number of byte-buffer entries.
REQ-004 Clk  in  1  sole clock; all logic is sampled on the rising edge of Clk.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 in_data  in  8  scan-code byte from the PS/2 receive stage.
REQ-007 in_valid  in  1  one-Clk strobe qualifying in_data.
REQ-008 in_ready  out  1  high when the buffer is not full.
REQ-009 serial_clk  out  1  divided clock to the AVR.
REQ-010 serial_out  out  1  serial data, MSB first.
REQ-011 sending  out  1  high while a frame's 8 data bits are on serial_out.
REQ-012 overflow  out  1  sticky flag: a byte was dropped.
REQ-013 fifo_count  out  3  buffer occupancy, 0..4.

Function
REQ-014 Divider counts 0..DIV-1 on every Clk; at DIV-1 it wraps to 0 and serial_clk toggles.
REQ-015 "Tick" is the Clk cycle in which serial_clk toggles 1->0; the state machine, serial_out and sending update only on ticks.
REQ-016 Tick period is 2*DIV Clk cycles.
REQ-017 Buffer is a circular FIFO with 2-bit read/write pointers that wrap 3->0.
REQ-018 Push occurs when in_valid=1 and fifo_count<4.
REQ-019 in_valid=1 with fifo_count=4: byte is discarded, buffer is unchanged, overflow is set to 1 on the next edge and held until Reset.
REQ-020 in_ready equals (fifo_count!=4) as registered before the current edge; a same-cycle pop does not admit a push into a full buffer.
REQ-021 Push and pop in the same cycle with fifo_count in 1..3: fifo_count is unchanged and both pointers advance.
REQ-022 FSM states are IDLE, SHIFT and GAP.
REQ-023 IDLE, on a tick with fifo_count>0: pop the head byte (encoded per REQ-033), load it into an 8-bit shift register, drive serial_out=bit7 and sending=1, set bit index 7, go to SHIFT.
REQ-024 IDLE, on a tick with an empty buffer: stay in IDLE; serial_out=0, sending=0.
REQ-025 SHIFT, on each tick: with index>0, decrement the index and drive the next lower bit; with index=0, go to GAP with serial_out=0, sending=0 and the gap counter=GAP_LEN-1.
REQ-026 GAP, on each tick: decrement the gap counter; on the tick where it reads 0, go to IDLE.
REQ-027 A frame is exactly 8 ticks with sending=1 followed by at least GAP_LEN+1 ticks with sending=0 (GAP_LEN ticks in GAP plus at least 1 in IDLE).
REQ-028 A byte pushed while the FSM is in IDLE with an empty buffer appears as bit7 on the first tick at least one Clk after the push.
REQ-029 A push in the same cycle as an IDLE tick on an empty buffer is not popped on that tick.

Reset
REQ-030 While Reset=1 at an edge: divider=0, serial_clk=0, FSM=IDLE, serial_out=0, sending=0, pointers=0, fifo_count=0, overflow=0, LFSR=16'hFFFF.
REQ-031 Reset asserted mid-frame aborts the frame; buffered bytes are lost and no partial bits are emitted after release.
REQ-032 in_ready=1 on the first edge after Reset deasserts.

Configuration
REQ-033 With SCAN_TX_CRYPT_EN defined:
- each popped byte is XORed with key = lfsr[7:0] before loading;
- the 16-bit LFSR then advances one step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]};
- the LFSR advances only on pops.
REQ-034 Without SCAN_TX_CRYPT_EN: popped bytes are sent unmodified and no LFSR logic is present.

Verification
REQ-035 Use DIV=2, GAP_LEN=4, crypt off. Push 0xA5 while idle -> over 8 consecutive ticks serial_out=1,0,1,0,0,1,0,1 with sending=1, then 5 ticks with sending=0.
REQ-036 Crypt on. Push 0x1C twice -> first frame transmits 0xE3 (key 0xFF), second frame transmits 0xE2 (key 0xFE).
REQ-037 Push 5 bytes in 5 consecutive Clk cycles while idle, ticks held off -> fifo_count=4, in_ready=0, 5th byte dropped, overflow=1; the 4 frames transmit the first 4 bytes in order.
REQ-038 Assert Reset during bit 3 of a frame -> next edge: sending=0, serial_out=0, fifo_count=0, overflow=0, serial_clk=0, LFSR=16'hFFFF.
REQ-039 Push 6 bytes spaced so the buffer crosses pointer wrap 3->0 -> all 6 bytes are transmitted in order; fifo_count never exceeds 4.
REQ-040 Push and pop in the same Clk cycle with fifo_count=2 -> fifo_count stays 2.

Source files
------------

// File: rtl/scan_tx.sv
// rtl/scan_tx.sv - PS/2 scan-code serialiser: 4-entry byte FIFO, divided serial clock, MSB-first frames.
// Optional byte scrambling with a 16-bit LFSR key when SCAN_TX_CRYPT_EN is defined.
module scan_tx #(
    parameter int DIV     = 250,
    parameter int GAP_LEN = 4,
    parameter int DEPTH   = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       serial_clk,
    output logic       serial_out,
    output logic       sending,
    output logic       overflow,
    output logic [2:0] fifo_count
);

    localparam logic [11:0] DIV_LAST = 12'(DIV - 1);
    localparam logic [3:0]  GAP_M1   = 4'(GAP_LEN - 1);
    localparam logic [2:0]  FULL     = 3'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    logic [11:0] div_q, div_d;
    logic        sclk_q, sclk_d;
    logic        tick;

    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        push, pop;
    logic [7:0]  load_byte;

    state_t      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  gap_q, gap_d;
    logic        sout_q, sout_d;
    logic        sending_q, sending_d;

    // Tick is the Clk cycle in which serial_clk falls.
    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        tick   = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            tick   = sclk_q;
        end else begin
            div_d = div_q + 12'd1;
        end
    end

    // in_ready comes from registered occupancy, so a pop never frees room for a same-cycle push.
    always_comb begin
        in_ready   = (count_q != FULL);
        push       = in_valid && in_ready;
        pop        = tick && (state_q == IDLE) && (count_q != 3'd0);
        overflow_d = overflow_q | (in_valid & ~in_ready);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

`ifdef SCAN_TX_CRYPT_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        load_byte = mem_q[rd_ptr_q] ^ lfsr_q[7:0];
        lfsr_d    = lfsr_q;
        if (pop) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr_q <= 16'hFFFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        load_byte = mem_q[rd_ptr_q];
    end
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        sout_d    = sout_q;
        sending_d = sending_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (count_q != 3'd0) begin
                        shreg_d   = load_byte;
                        sout_d    = load_byte[7];
                        sending_d = 1'b1;
                        idx_d     = 3'd7;
                        state_d   = SHIFT;
                    end else begin
                        sout_d    = 1'b0;
                        sending_d = 1'b0;
                    end
                end
                SHIFT: begin
                    if (idx_q != 3'd0) begin
                        idx_d  = idx_q - 3'd1;
                        sout_d = shreg_q[idx_q - 3'd1];
                    end else begin
                        sout_d    = 1'b0;
                        sending_d = 1'b0;
                        gap_d     = GAP_M1;
                        state_d   = GAP;
                    end
                end
                GAP: begin
                    if (gap_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    sout_d    = 1'b0;
                    sending_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q      <= '0;
            sclk_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            sout_q     <= 1'b0;
            sending_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            sclk_q     <= sclk_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            sout_q     <= sout_d;
            sending_q  <= sending_d;
        end
    end

    // Buffer contents need no reset: occupancy alone decides what is valid.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    assign serial_clk = sclk_q;
    assign serial_out = sout_q;
    assign sending    = sending_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_scan_tx.sv
// tb/tb_scan_tx.sv - directed bench for scan_tx: fast instance (DIV=2) and slow instance (DIV=16).
module tb_scan_tx;

    localparam int GAP = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid_a = 1'b0;
    logic       in_valid_b = 1'b0;

    logic       a_ready, a_sclk, a_sout, a_send, a_ovf;
    logic [2:0] a_cnt;
    logic       b_ready, b_sclk, b_sout, b_send, b_ovf;
    logic [2:0] b_cnt;

    always #5 Clk = ~Clk;

    scan_tx #(.DIV(2), .GAP_LEN(GAP), .DEPTH(4)) u_a (
        .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_valid(in_valid_a),
        .in_ready(a_ready), .serial_clk(a_sclk), .serial_out(a_sout),
        .sending(a_send), .overflow(a_ovf), .fifo_count(a_cnt)
    );

    scan_tx #(.DIV(16), .GAP_LEN(GAP), .DEPTH(4)) u_b (
        .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_valid(in_valid_b),
        .in_ready(b_ready), .serial_clk(b_sclk), .serial_out(b_sout),
        .sending(b_send), .overflow(b_ovf), .fifo_count(b_cnt)
    );

    int checks = 0;
    int fails  = 0;
    int edge_n;

    always @(posedge Clk) begin
        if (Reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame monitor for both instances, sampled on the falling Clk edge.
    logic [1:0] sclk_w, sout_w, send_w;
    logic [2:0] cnt_w [2];
    assign sclk_w = {b_sclk, a_sclk};
    assign sout_w = {b_sout, a_sout};
    assign send_w = {b_send, a_send};
    assign cnt_w[0] = a_cnt;
    assign cnt_w[1] = b_cnt;

    logic       prev_sclk [2];
    int         nbits [2];
    int         zrun [2];
    bit         seen [2];
    logic [7:0] acc [2];
    int         rx_cnt [2];
    logic [7:0] rx_data [2][32];
    logic [2:0] max_cnt [2];

    always @(negedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                prev_sclk[i] = 1'b0;
                nbits[i]     = 0;
                zrun[i]      = 0;
                seen[i]      = 1'b0;
                rx_cnt[i]    = 0;
                max_cnt[i]   = 3'd0;
            end else begin
                if (cnt_w[i] > max_cnt[i]) max_cnt[i] = cnt_w[i];
                if (prev_sclk[i] && !sclk_w[i]) begin
                    if (send_w[i]) begin
                        if (nbits[i] == 0 && seen[i]) begin
                            checks++;
                            if (zrun[i] < GAP + 1) begin
                                fails++;
                                $display("FAIL gap_len inst%0d: got %0d ticks required >= %0d", i, zrun[i], GAP + 1);
                            end
                        end
                        acc[i]   = {acc[i][6:0], sout_w[i]};
                        nbits[i] = nbits[i] + 1;
                        zrun[i]  = 0;
                    end else begin
                        if (nbits[i] != 0) begin
                            checks++;
                            if (nbits[i] != 8) begin
                                fails++;
                                $display("FAIL frame_len inst%0d: got %0d bits required 8", i, nbits[i]);
                            end else if (rx_cnt[i] < 32) begin
                                rx_data[i][rx_cnt[i]] = acc[i];
                                rx_cnt[i] = rx_cnt[i] + 1;
                            end
                            seen[i]  = 1'b1;
                            nbits[i] = 0;
                        end
                        zrun[i] = zrun[i] + 1;
                    end
                end
                prev_sclk[i] = sclk_w[i];
            end
        end
    end

    // Reference key stream, one step per transmitted byte.
    logic [15:0] mlfsr [2];

    task automatic enc(input int i, input logic [7:0] b, output logic [7:0] e);
        e = b;
`ifdef SCAN_TX_CRYPT_EN
        e = b ^ mlfsr[i][7:0];
`endif
        mlfsr[i] = {mlfsr[i][14:0], mlfsr[i][15] ^ mlfsr[i][13] ^ mlfsr[i][12] ^ mlfsr[i][10]};
    endtask

    task automatic expect_rx(input int i, input int idx, input logic [7:0] plain, input string name);
        logic [7:0] e;
        enc(i, plain, e);
        check(name, rx_data[i][idx], e);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_to(input int k);
        while (edge_n < k) step();
    endtask

    task automatic push_at(input int k, input int i, input logic [7:0] d);
        run_to(k - 1);
        in_data = d;
        if (i == 0) in_valid_a = 1'b1;
        else        in_valid_b = 1'b1;
        step();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic wait_rx(input int i, input int n, input int budget, input string name);
        int k = 0;
        while (rx_cnt[i] < n && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(rx_cnt[i] >= n), 32'd1);
    endtask

    task automatic do_reset();
        Reset      = 1'b1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        repeat (3) step();
        Reset    = 1'b0;
        mlfsr[0] = 16'hFFFF;
        mlfsr[1] = 16'hFFFF;
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [2:0] exp_cnt;
        logic       exp_ready;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] e0, e1, x0, x1;

        vecs[0] = '{1'b1, 8'h11, 3'd1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h22, 3'd2, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h33, 3'd3, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h44, 3'd4, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h55, 3'd4, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h66, 3'd4, 1'b0, 1'b1};

        // Reset state while Reset is held.
        repeat (3) step();
        check("rst_sclk", a_sclk, 1'b0);
        check("rst_sout", a_sout, 1'b0);
        check("rst_send", a_send, 1'b0);
        check("rst_cnt", a_cnt, 3'd0);
        check("rst_ovf", a_ovf, 1'b0);
        check("rst_cnt_b", b_cnt, 3'd0);
        Reset    = 1'b0;
        mlfsr[0] = 16'hFFFF;
        mlfsr[1] = 16'hFFFF;
        step();
        check("ready_after_rst", a_ready, 1'b1);

        // Single byte while idle, pushed on a tick edge, then a second byte queued.
        push_at(4, 0, 8'hA5);
        check("tick_push_cnt", a_cnt, 3'd1);
        check("tick_push_nopop", a_send, 1'b0);
        push_at(5, 0, 8'h3C);
        check("two_cnt", a_cnt, 3'd2);
        enc(0, 8'hA5, e0);
        for (int b = 0; b < 8; b++) begin
            run_to(8 + 4 * b);
            check($sformatf("a5_bit%0d", 7 - b), {a_send, a_sout}, {1'b1, e0[7 - b]});
        end
        for (int j = 0; j < 5; j++) begin
            run_to(40 + 4 * j);
            check($sformatf("a5_gap%0d", j), {a_send, a_sout}, 2'b00);
        end
        run_to(60);
        check("second_start", a_send, 1'b1);
        wait_rx(0, 2, 200, "a5_frames");
        check("a5_rx", rx_data[0][0], e0);
        expect_rx(0, 1, 8'h3C, "3c_rx");

        // Repeated byte gets a different key each frame.
        do_reset();
        push_at(1, 0, 8'h1C);
        push_at(2, 0, 8'h1C);
        wait_rx(0, 2, 400, "crypt_frames");
`ifdef SCAN_TX_CRYPT_EN
        x0 = 8'hE3;
        x1 = 8'hE2;
`else
        x0 = 8'h1C;
        x1 = 8'h1C;
`endif
        check("crypt_rx0", rx_data[0][0], x0);
        check("crypt_rx1", rx_data[0][1], x1);

        // Five back-to-back pushes into the slow instance before its first tick.
        do_reset();
        for (int v = 0; v < 6; v++) begin
            in_data    = vecs[v].data;
            in_valid_b = vecs[v].valid;
            step();
            in_valid_b = 1'b0;
            check($sformatf("fill%0d_cnt", v), b_cnt, vecs[v].exp_cnt);
            check($sformatf("fill%0d_ready", v), b_ready, vecs[v].exp_ready);
            check($sformatf("fill%0d_ovf", v), b_ovf, vecs[v].exp_ovf);
        end
        wait_rx(1, 4, 3000, "fill_frames");
        repeat (500) step();
        check("fill_nframes", rx_cnt[1], 32'd4);
        check("fill_ovf_held", b_ovf, 1'b1);
        for (int v = 0; v < 4; v++) expect_rx(1, v, vecs[v].data, $sformatf("fill_rx%0d", v));

        // Simultaneous push/pop at occupancy 2, then pointer wrap over six bytes.
        do_reset();
        push_at(2, 0, 8'h61);
        push_at(3, 0, 8'h62);
        push_at(4, 0, 8'h63);
        check("pushpop_cnt", a_cnt, 3'd2);
        check("pushpop_send", a_send, 1'b1);
        push_at(10, 0, 8'h64);
        push_at(11, 0, 8'h65);
        check("wrap_full", a_cnt, 3'd4);
        push_at(60, 0, 8'h66);
        wait_rx(0, 6, 600, "wrap_frames");
        for (int v = 0; v < 6; v++) expect_rx(0, v, 8'(8'h61 + v), $sformatf("wrap_rx%0d", v));
        check("wrap_max_cnt", 32'(max_cnt[0] <= 3'd4), 32'd1);
        check("wrap_no_ovf", a_ovf, 1'b0);

        // Reset during bit 3 with a full buffer and overflow set.
        do_reset();
        push_at(1, 0, 8'h71);
        for (int v = 0; v < 5; v++) push_at(5 + v, 0, 8'(8'h72 + v));
        run_to(21);
        check("mid_ovf", a_ovf, 1'b1);
        check("mid_cnt", a_cnt, 3'd4);
        check("mid_send", a_send, 1'b1);
        Reset = 1'b1;
        step();
        check("abort_send", a_send, 1'b0);
        check("abort_sout", a_sout, 1'b0);
        check("abort_cnt", a_cnt, 3'd0);
        check("abort_ovf", a_ovf, 1'b0);
        check("abort_sclk", a_sclk, 1'b0);
        repeat (2) step();
        Reset    = 1'b0;
        mlfsr[0] = 16'hFFFF;
        mlfsr[1] = 16'hFFFF;
        repeat (200) step();
        check("abort_no_bits", rx_cnt[0], 32'd0);
        push_at(201, 0, 8'h1C);
        wait_rx(0, 1, 200, "post_abort_frame");
        check("post_abort_rx", rx_data[0][0], x0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
